// File: rtl/click_decoder.sv
// Click-group decoder: folds single-cycle click pulses into single/double/triple
// events and presents them through a valid/ack holding register.
module click_decoder #(
    parameter int unsigned WINDOW = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pulse,
    input  logic       ack,
    output logic       evt_valid,
    output logic [1:0] evt_code,
    output logic       evt_overrun,
    output logic [7:0] total_clicks
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    localparam logic [23:0] TIMEOUT = 24'(WINDOW - 1);

    state_t      state_r;
    state_t      state_s;
    logic [1:0]  clicks_r;
    logic [1:0]  clicks_s;
    logic [23:0] timer_r;
    logic [23:0] timer_s;
    logic        emit_s;
    logic [1:0]  emit_code_s;

    logic        evt_valid_r;
    logic        evt_valid_s;
    logic [1:0]  evt_code_r;
    logic [1:0]  evt_code_s;
    logic        evt_overrun_r;
    logic        evt_overrun_s;
    logic [7:0]  total_clicks_r;
    logic [7:0]  total_clicks_s;

    // Group-tracking state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= IDLE;
            clicks_r <= 2'd0;
            timer_r  <= 24'd0;
        end else begin
            state_r  <= state_s;
            clicks_r <= clicks_s;
            timer_r  <= timer_s;
        end
    end

    // Next-state logic; a pulse always beats the window timeout
    always_comb begin
        state_s     = state_r;
        clicks_s    = clicks_r;
        timer_s     = timer_r;
        emit_s      = 1'b0;
        emit_code_s = 2'b00;
        case (state_r)
            IDLE: begin
                if (pulse) begin
                    state_s  = WAIT;
                    clicks_s = 2'd1;
                    timer_s  = 24'd0;
                end else begin
                    state_s  = IDLE;
                end
            end
            WAIT: begin
                if (pulse) begin
                    if (clicks_r == 2'd2) begin
                        emit_s      = 1'b1;
                        emit_code_s = 2'b11;
                        state_s     = IDLE;
                        clicks_s    = 2'd0;
                        timer_s     = 24'd0;
                    end else begin
                        clicks_s    = clicks_r + 2'd1;
                        timer_s     = 24'd0;
                    end
                end else if (timer_r == TIMEOUT) begin
                    emit_s      = 1'b1;
                    emit_code_s = clicks_r;
                    state_s     = IDLE;
                    clicks_s    = 2'd0;
                    timer_s     = 24'd0;
                end else begin
                    timer_s     = timer_r + 24'd1;
                end
            end
            default: begin
                state_s  = IDLE;
                clicks_s = 2'd0;
                timer_s  = 24'd0;
            end
        endcase
    end

    // Event holding register: a new event may replace the old one only when it is being acked
    always_comb begin
        evt_valid_s    = evt_valid_r;
        evt_code_s     = evt_code_r;
        evt_overrun_s  = evt_overrun_r;
        total_clicks_s = total_clicks_r;
        if (emit_s) begin
            if (!evt_valid_r || ack) begin
                evt_valid_s = 1'b1;
                evt_code_s  = emit_code_s;
            end else begin
                evt_overrun_s = 1'b1;
            end
        end else if (evt_valid_r && ack) begin
            evt_valid_s = 1'b0;
        end else begin
            evt_valid_s = evt_valid_r;
        end
        if (pulse) begin
            total_clicks_s = total_clicks_r + 8'd1;
        end else begin
            total_clicks_s = total_clicks_r;
        end
    end

    // Registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            evt_valid_r    <= 1'b0;
            evt_code_r     <= 2'b00;
            evt_overrun_r  <= 1'b0;
            total_clicks_r <= 8'd0;
        end else begin
            evt_valid_r    <= evt_valid_s;
            evt_code_r     <= evt_code_s;
            evt_overrun_r  <= evt_overrun_s;
            total_clicks_r <= total_clicks_s;
        end
    end

    assign evt_valid    = evt_valid_r;
    assign evt_code     = evt_code_r;
    assign evt_overrun  = evt_overrun_r;
    assign total_clicks = total_clicks_r;

endmodule
